// File: rtl/key_pkg.sv
// Shared definitions for the push-button front end: per-key FSM encoding and
// the 1 kHz tick divider computation.
package key_pkg;

  localparam logic [1:0] KS_RELEASED    = 2'd0;
  localparam logic [1:0] KS_PRESS_CHK   = 2'd1;
  localparam logic [1:0] KS_PRESSED     = 2'd2;
  localparam logic [1:0] KS_RELEASE_CHK = 2'd3;

  typedef enum logic [1:0] {
    ST_RELEASED    = KS_RELEASED,
    ST_PRESS_CHK   = KS_PRESS_CHK,
    ST_PRESSED     = KS_PRESSED,
    ST_RELEASE_CHK = KS_RELEASE_CHK
  } key_state_e;

  function automatic int tick_div(input int clk_freq_hz);
    return clk_freq_hz / 1000;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM, hold counter and the
// registered press/release/long event pulses.
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_key_n,
  input  logic       i_tick,
  output logic       o_level,
  output logic       o_press,
  output logic       o_release,
  output logic       o_long,
  output logic [1:0] o_state
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + 1);

  logic              sync1_q, sync2_q;
  logic              raw_p;
  key_state_e        state_q, state_d;
  logic [DB_W-1:0]   db_q, db_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;
  logic              level_now;

  assign raw_p     = ~sync2_q;
  assign level_now = (state_q == ST_PRESSED) || (state_q == ST_RELEASE_CHK);

  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    hold_d    = hold_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    // A raw revert takes priority over a coincident tick.
    case (state_q)
      ST_RELEASED: begin
        if (raw_p) begin
          state_d = ST_PRESS_CHK;
          db_d    = '0;
        end
      end
      ST_PRESS_CHK: begin
        if (!raw_p) begin
          state_d = ST_RELEASED;
          db_d    = '0;
        end else if (i_tick) begin
          db_d = db_q + 1'b1;
          if (db_q == DB_W'(DEBOUNCE_MS - 1)) begin
            state_d = ST_PRESSED;
            press_d = 1'b1;
          end
        end
      end
      ST_PRESSED: begin
        if (!raw_p) begin
          state_d = ST_RELEASE_CHK;
          db_d    = '0;
        end
      end
      ST_RELEASE_CHK: begin
        if (raw_p) begin
          state_d = ST_PRESSED;
        end else if (i_tick) begin
          db_d = db_q + 1'b1;
          if (db_q == DB_W'(DEBOUNCE_MS - 1)) begin
            state_d   = ST_RELEASED;
            release_d = 1'b1;
          end
        end
      end
      default: state_d = ST_RELEASED;
    endcase

    // Hold time only accrues while the debounced level is high, and saturates.
    if (press_d) begin
      hold_d = '0;
    end else if (i_tick && level_now && (hold_q != HOLD_W'(LONG_MS))) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_q == HOLD_W'(LONG_MS - 1));
    end

    level_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_CHK);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      state_q   <= ST_RELEASED;
      db_q      <= '0;
      hold_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= i_key_n;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      db_q      <= db_d;
      hold_q    <= hold_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_state   = state_q;

endmodule

// File: rtl/key_debounce_go.sv
// Push-button front end: shared 1 kHz tick divider plus NUM_KEYS independent
// debounce channels. o_dbg_state packs each channel's FSM state (2 bits/key).
module key_debounce_go
  import key_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int NUM_KEYS    = 4,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_KEYS-1:0]   i_key_n,
  output logic                  o_pls_1k,
  output logic [NUM_KEYS-1:0]   o_level,
  output logic [NUM_KEYS-1:0]   o_press,
  output logic [NUM_KEYS-1:0]   o_release,
  output logic [NUM_KEYS-1:0]   o_long,
  output logic [2*NUM_KEYS-1:0] o_dbg_state
);

  localparam int DIV   = tick_div(CLK_FREQ_HZ);
  localparam int DIV_W = $clog2(DIV);

  logic [DIV_W-1:0] div_q;
  logic             div_last;
  logic             pls_q;

  assign div_last = (div_q == DIV_W'(DIV - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div_q <= '0;
      pls_q <= 1'b0;
    end else begin
      pls_q <= div_last;
      div_q <= div_last ? '0 : div_q + 1'b1;
    end
  end

  assign o_pls_1k = pls_q;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .LONG_MS    (LONG_MS)
    ) u_ch (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_key_n  (i_key_n[k]),
      .i_tick   (pls_q),
      .o_level  (o_level[k]),
      .o_press  (o_press[k]),
      .o_release(o_release[k]),
      .o_long   (o_long[k]),
      .o_state  (o_dbg_state[2*k +: 2])
    );
  end

endmodule
